pwm_i2c_reg_bridge: RTL and testbench
=====================================

Name: pwm_i2c_reg_bridge

Overview:
- I2C slave front end for the PWM register block; converts I2C bus transactions into single-cycle register write/read strobes.
- Sits directly upstream of the PWM register block and drives its addr/wdata/write/read inputs; consumes its 16-bit read data.
- Supports an 8-bit register pointer with auto-increment and 16-bit words carried as two bytes, high byte first.
- Standard-mode/fast-mode bus; oversampled by the PWM clock.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit I2C device address matched against the first byte.
- DATA_WIDTH, 16, register data width; fixed at 2 bytes.

Ports:
- clk_psc_i  in  1  module clock; must be at least 16x the SCL frequency.
- rst_n_i  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C SCL, asynchronous.
- sda_i  in  1  I2C SDA input, asynchronous.
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr_o  out  8  register pointer presented to the register block.
- reg_wdata_o  out  16  write data, valid while reg_write_o=1.
- reg_write_o  out  1  one-cycle write strobe.
- reg_read_o  out  1  one-cycle read request.
- reg_rdata_i  in  16  register read data, valid 1 cycle after reg_read_o.
- busy_o  out  1  1 while addressed, from START+address match until STOP.

Behaviour:
- Reset: all outputs 0; pointer 0x00; FSM in IDLE. Asynchronous assertion; a reset mid-transaction aborts it silently.
- Input conditioning and edge detection:
  - scl_i and sda_i each pass a 2-flop synchronizer plus 1 history flop.
  - Edges are detected on the synchronized signals.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit timing:
  - Sample SDA on the SCL rising-edge detect.
  - Update sda_oe_o only on the SCL falling-edge detect.
- Bit counter: 3 bits. A byte is 8 bits, MSB first; the 9th clock is the ACK slot.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Address match -> ADDR_ACK (drive ACK).
    - Mismatch -> WAIT_STOP (SDA released, no ACK).
  - ADDR_ACK: after the ACK bit, branch on R/W.
    - R/W=0 -> PTR.
    - R/W=1 -> pulse reg_read_o with the current pointer, then RD_HI.
  - PTR: shift 8 bits into the pointer -> PTR_ACK (ACK) -> WR_HI.
  - WR_HI: shift high byte -> ACK -> WR_LO.
  - WR_LO: shift low byte. In the cycle after the 8th bit is sampled:
    - reg_write_o=1 for 1 cycle, with reg_addr_o=pointer and reg_wdata_o={hi,lo}.
    - ACK, then pointer+1 (8-bit wrap 0xFF->0x00), then -> WR_HI.
  - RD_HI / RD_LO: capture reg_rdata_i 1 cycle after reg_read_o; shift out the high byte, then the low byte.
    - sda_oe_o = ~bit.
    - Release SDA in the master ACK slot and sample the master's ACK.
    - After RD_LO with master ACK: pointer+1, pulse reg_read_o, then -> RD_HI.
    - Master NACK after either byte -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bus until STOP or START.
- Global bus conditions:
  - STOP in any state -> IDLE; sda_oe_o=0.
  - A partially received word (high byte only) is discarded; no write.
  - Repeated START in any state -> ADDR. The pointer is retained, so a write-pointer-then-repeated-START-read sequence works.
- busy_o: 1 from the address ACK until STOP, or until a mismatched repeated-START address.
- Simultaneous events:
  - START/STOP detection takes priority over SCL edge processing in the same cycle.
  - reg_write_o and reg_read_o never assert together.
- Outputs:
  - reg_addr_o holds the pointer at all times.
  - reg_wdata_o holds its last written value.

Test Plan:
- Write: START, 0xA0, 0x04, 0x12, 0x34, STOP -> ACK on all 4 bytes; exactly one reg_write_o pulse with addr 0x04, data 0x1234; busy_o low after STOP.
- Burst write: ptr 0x04, data 0x1111, 0x2222 -> two pulses, (0x04, 0x1111) then (0x05, 0x2222).
- Address mismatch: first byte 0xA2 -> SDA not pulled in the ACK slot; no strobes; busy_o stays 0 until STOP.
- Read: write ptr 0x02, repeated START, 0xA1, reg_rdata_i=0xBEEF, master ACK then NACK -> reg_read_o at ptr 0x02, 0x03; bus bytes 0xBE, 0xEF, then the high byte of the 0x03 data.
- Wrap/abort:
  - Pointer 0xFF word write -> writes 0xFF; next word writes 0x00.
  - STOP after only the high byte -> no reg_write_o.
- Reset: assert rst_n_i mid-byte with sda_oe_o=1 -> sda_oe_o=0 and all strobes 0 immediately; the next transaction succeeds normally.

Source files
------------

// File: rtl/pwm_i2c_reg_bridge.sv
// I2C slave front end for the PWM register block: turns bus transactions into
// single-cycle register write/read strobes with an auto-incrementing 8-bit pointer.
`timescale 1ns/1ps
module pwm_i2c_reg_bridge #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATA_WIDTH = 16
) (
  input  logic                  clk_psc_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [7:0]            reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  reg_write_o,
  output logic                  reg_read_o,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR_HI, ST_WR_HI_ACK, ST_WR_LO, ST_WR_LO_ACK,
    ST_RD_HI, ST_RD_HI_ACK, ST_RD_LO, ST_RD_LO_ACK, ST_WAIT_STOP
  } state_t;

  // [0],[1] synchronize, [2] is history; reset to the idle-bus level so no
  // spurious edge follows reset.
  logic [2:0] scl_q, sda_q;

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  logic scl_s, scl_d, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign scl_d     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_d     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t                  state, state_n;
  logic [2:0]              bit_cnt, bit_cnt_n;
  logic [7:0]              shift, shift_n;
  logic [7:0]              hi_byte, hi_n;
  logic [DATA_WIDTH-1:0]   rbuf, rbuf_n;
  logic                    rd_cap;
  logic                    in_slot, in_slot_n;
  logic                    mack, mack_n;
  logic [7:0]              ptr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic                    write_n, read_n, oe_n, busy_n;
  logic [7:0]              byte_in, tx_byte;
  logic                    tx_bit;

  assign byte_in = {shift[6:0], sda_s};
  assign tx_byte = (state == ST_RD_LO) ? rbuf[7:0] : rbuf[15:8];
  assign tx_bit  = tx_byte[3'd7 - bit_cnt];

  // in_slot marks that the ACK slot's opening SCL fall has been seen; the next
  // fall closes the slot.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    hi_n      = hi_byte;
    in_slot_n = in_slot;
    mack_n    = mack;
    ptr_n     = reg_addr_o;
    wdata_n   = reg_wdata_o;
    write_n   = 1'b0;
    read_n    = 1'b0;
    oe_n      = sda_oe_o;
    busy_n    = busy_o;
    rbuf_n    = rd_cap ? reg_rdata_i : rbuf;

    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      in_slot_n = 1'b0;
      oe_n      = 1'b0;
    end else if (stop_det) begin
      state_n   = ST_IDLE;
      in_slot_n = 1'b0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_HI, ST_WR_LO: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              in_slot_n = 1'b0;
              case (state)
                ST_ADDR: begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    state_n = ST_ADDR_ACK;
                    busy_n  = 1'b1;
                    read_n  = byte_in[0];
                  end else begin
                    state_n = ST_WAIT_STOP;
                    busy_n  = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_n   = byte_in;
                  state_n = ST_PTR_ACK;
                end
                ST_WR_HI: begin
                  hi_n    = byte_in;
                  state_n = ST_WR_HI_ACK;
                end
                default: begin
                  write_n = 1'b1;
                  wdata_n = {hi_byte, byte_in};
                  state_n = ST_WR_LO_ACK;
                end
              endcase
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_HI_ACK, ST_WR_LO_ACK: begin
          if (scl_fall) begin
            if (!in_slot) begin
              oe_n      = 1'b1;
              in_slot_n = 1'b1;
            end else begin
              oe_n      = 1'b0;
              in_slot_n = 1'b0;
              bit_cnt_n = '0;
              case (state)
                ST_ADDR_ACK: begin
                  // shift still holds the address byte; bit 0 is R/W
                  if (shift[0]) begin
                    state_n = ST_RD_HI;
                    oe_n    = ~rbuf[15];
                  end else begin
                    state_n = ST_PTR;
                  end
                end
                ST_PTR_ACK:   state_n = ST_WR_HI;
                ST_WR_HI_ACK: state_n = ST_WR_LO;
                default: begin
                  ptr_n   = reg_addr_o + 8'd1;
                  state_n = ST_WR_HI;
                end
              endcase
            end
          end
        end

        ST_RD_HI, ST_RD_LO: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              in_slot_n = 1'b0;
              state_n   = (state == ST_RD_HI) ? ST_RD_HI_ACK : ST_RD_LO_ACK;
            end
          end else if (scl_fall) begin
            oe_n = ~tx_bit;
          end
        end

        ST_RD_HI_ACK, ST_RD_LO_ACK: begin
          if (scl_fall && !in_slot) begin
            oe_n      = 1'b0;
            in_slot_n = 1'b1;
          end else if (scl_rise && in_slot) begin
            mack_n = ~sda_s;
            // prefetch the next word now so it is captured before the slot ends
            if (state == ST_RD_LO_ACK && !sda_s) begin
              ptr_n  = reg_addr_o + 8'd1;
              read_n = 1'b1;
            end
          end else if (scl_fall) begin
            in_slot_n = 1'b0;
            bit_cnt_n = '0;
            if (!mack) begin
              state_n = ST_WAIT_STOP;
              oe_n    = 1'b0;
            end else if (state == ST_RD_HI_ACK) begin
              state_n = ST_RD_LO;
              oe_n    = ~rbuf[7];
            end else begin
              state_n = ST_RD_HI;
              oe_n    = ~rbuf[15];
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      hi_byte     <= '0;
      rbuf        <= '0;
      rd_cap      <= 1'b0;
      in_slot     <= 1'b0;
      mack        <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_write_o <= 1'b0;
      reg_read_o  <= 1'b0;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      hi_byte     <= hi_n;
      rbuf        <= rbuf_n;
      rd_cap      <= reg_read_o;
      in_slot     <= in_slot_n;
      mack        <= mack_n;
      reg_addr_o  <= ptr_n;
      reg_wdata_o <= wdata_n;
      reg_write_o <= write_n;
      reg_read_o  <= read_n;
      sda_oe_o    <= oe_n;
      busy_o      <= busy_n;
    end
  end

endmodule

// File: tb/tb_pwm_i2c_reg_bridge.sv
// Self-checking bench: an I2C master drives randomized transactions and a
// transaction-level model predicts register strobes and read-back bytes.
`timescale 1ns/1ps
module tb_pwm_i2c_reg_bridge;

  localparam int Q = 6;  // quarter SCL period in clocks (SCL = clk/24)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_write;
  logic        reg_read;
  logic [15:0] reg_rdata = '0;
  logic        busy;

  assign sda_line = m_sda & ~sda_oe;

  pwm_i2c_reg_bridge #(.SLAVE_ADDR(7'h50), .DATA_WIDTH(16)) dut (
    .clk_psc_i   (clk),
    .rst_n_i     (rst_n),
    .scl_i       (m_scl),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_write_o (reg_write),
    .reg_read_o  (reg_read),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] regfile [256];
  logic [7:0]  m_ptr = '0;
  logic [23:0] exp_wr[$], obs_wr[$];
  logic [7:0]  exp_rd[$], obs_rd[$];
  logic [15:0] tx_words[$];
  int          overlap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-block stand-in: data valid the cycle after the read request.
  always @(posedge clk) if (reg_read) reg_rdata <= regfile[reg_addr];

  always @(negedge clk) begin
    if (reg_write) obs_wr.push_back({reg_addr, reg_wdata});
    if (reg_read)  obs_rd.push_back(reg_addr);
    if (reg_write && reg_read) overlap++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_clks(Q);
      m_scl = 1'b1; wait_clks(2 * Q);
      m_scl = 1'b0; wait_clks(Q);
    end
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    acked = ~sda_line;
    wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    b = '0;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clks(Q);
      m_scl = 1'b1; wait_clks(Q);
      b = {b[6:0], sda_line};
      wait_clks(Q);
      m_scl = 1'b0; wait_clks(Q);
    end
    m_sda = ~ack; wait_clks(Q);
    m_scl = 1'b1; wait_clks(2 * Q);
    m_scl = 1'b0; wait_clks(Q);
    m_sda = 1'b1;
  endtask

  task automatic compare_queues();
    check("wr_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      check("wr_entry", obs_wr[i], exp_wr[i]);
    check("rd_count", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
      check("rd_addr", obs_rd[i], exp_rd[i]);
    obs_wr.delete(); exp_wr.delete();
    obs_rd.delete(); exp_rd.delete();
  endtask

  // Write transaction: address, pointer, every word in tx_words, and
  // optionally one dangling high byte before STOP.
  task automatic do_write(input logic [6:0] addr7, input logic [7:0] ptr, input bit half);
    logic acked;
    logic match;
    match = (addr7 == 7'h50);
    bus_start();
    send_byte({addr7, 1'b0}, acked);
    check("wr_addr_ack", acked, match);
    check("wr_busy", busy, match);
    send_byte(ptr, acked);
    check("wr_ptr_ack", acked, match);
    if (match) m_ptr = ptr;
    foreach (tx_words[i]) begin
      send_byte(tx_words[i][15:8], acked);
      check("wr_hi_ack", acked, match);
      send_byte(tx_words[i][7:0], acked);
      check("wr_lo_ack", acked, match);
      if (match) begin
        exp_wr.push_back({m_ptr, tx_words[i]});
        m_ptr = m_ptr + 8'd1;
      end
    end
    if (half) begin
      send_byte(8'($urandom), acked);
      check("wr_half_ack", acked, match);
    end
    bus_stop();
    wait_clks(4);
    check("wr_busy_after_stop", busy, 1'b0);
    compare_queues();
  endtask

  // Set the pointer, repeated START, then read nbytes (NACK on the last).
  task automatic do_read(input logic [7:0] ptr, input int nbytes);
    logic       acked;
    logic [7:0] b, expb;
    bus_start();
    send_byte(8'hA0, acked);
    check("rd_wr_addr_ack", acked, 1'b1);
    send_byte(ptr, acked);
    check("rd_ptr_ack", acked, 1'b1);
    m_ptr = ptr;
    bus_start();
    send_byte(8'hA1, acked);
    check("rd_addr_ack", acked, 1'b1);
    exp_rd.push_back(m_ptr);
    for (int k = 0; k < nbytes; k++) begin
      expb = (k % 2 == 0) ? regfile[m_ptr][15:8] : regfile[m_ptr][7:0];
      recv_byte(k < nbytes - 1, b);
      check("rd_byte", b, expb);
      if (k % 2 == 1 && k < nbytes - 1) begin
        m_ptr = m_ptr + 8'd1;
        exp_rd.push_back(m_ptr);
      end
    end
    check("rd_busy", busy, 1'b1);
    bus_stop();
    wait_clks(4);
    check("rd_busy_after_stop", busy, 1'b0);
    compare_queues();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"},    sda_oe,    1'b0);
    check({tag, "_write"}, reg_write, 1'b0);
    check({tag, "_read"},  reg_read,  1'b0);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_addr"},  reg_addr,  8'h00);
  endtask

  initial begin
    logic acked;
    int   budget;
    for (int i = 0; i < 256; i++) regfile[i] = 16'($urandom);

    wait_clks(4);
    check_reset_outputs("reset");
    check("reset_wdata", reg_wdata, 16'h0000);
    rst_n = 1'b1;
    wait_clks(6);

    // Single word write
    tx_words = '{16'h1234};
    do_write(7'h50, 8'h04, 1'b0);

    // Burst write
    tx_words = '{16'h1111, 16'h2222};
    do_write(7'h50, 8'h04, 1'b0);

    // Address mismatch (0xA2) plus random wrong addresses
    tx_words = '{16'h5555};
    do_write(7'h51, 8'h10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      logic [6:0] a;
      a = 7'($urandom);
      if (a == 7'h50) a = 7'h2A;
      tx_words = '{16'($urandom)};
      do_write(a, 8'($urandom), 1'b0);
    end

    // Read with repeated START
    regfile[8'h02] = 16'hBEEF;
    do_read(8'h02, 3);

    // Pointer wrap
    tx_words = '{16'($urandom), 16'($urandom)};
    do_write(7'h50, 8'hFF, 1'b0);

    // STOP after a lone high byte: no write, and no dangling write after it
    tx_words.delete();
    do_write(7'h50, 8'($urandom), 1'b1);
    tx_words = '{16'($urandom)};
    do_write(7'h50, 8'($urandom), 1'b1);

    // Random mix
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(1, 0) == 0) begin
        int n;
        n = $urandom_range(3, 1);
        tx_words.delete();
        for (int j = 0; j < n; j++) tx_words.push_back(16'($urandom));
        do_write(7'h50, 8'($urandom), 1'($urandom));
      end else begin
        do_read(8'($urandom), $urandom_range(5, 1));
      end
    end

    // Reset while the slave is pulling SDA low during a read byte
    regfile[m_ptr] = 16'h0000;
    bus_start();
    send_byte(8'hA1, acked);
    check("rst_addr_ack", acked, 1'b1);
    exp_rd.push_back(m_ptr);
    for (int i = 0; i < 3; i++) begin
      wait_clks(Q);
      m_scl = 1'b1; wait_clks(2 * Q);
      m_scl = 1'b0; wait_clks(Q);
    end
    budget = 0;
    while (!sda_oe && budget < 20) begin
      wait_clks(1);
      budget++;
    end
    check("rst_pre_oe", sda_oe, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    compare_queues();
    wait_clks(3);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    m_ptr = 8'h00;
    wait_clks(6);
    tx_words = '{16'($urandom), 16'($urandom)};
    do_write(7'h50, 8'($urandom), 1'b0);
    do_read(8'($urandom), 2);

    check("no_write_read_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
